// File: rtl/axi_full_slave_latency_mem.sv
// axi_full_slave_latency_mem -- AXI4 slave backed by a word-addressed memory,
// with a fixed write-response latency and a fixed read-data latency.
// The write and read paths are independent FSMs with one burst in flight each.
// Build option: define AXI_SLV_BACKPRESSURE_EN to insert a one-cycle WREADY /
// RVALID bubble after every W / R handshake (half throughput).
module axi_full_slave_latency_mem #(
    parameter int ID_W   = 1,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8,
    parameter int WR_LAT = 4,
    parameter int RD_LAT = 4,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W),
    localparam int ADDR_W = MEM_AW + OFF_W
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [ID_W-1:0]   S_AXI_AWID,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [7:0]        S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [DATA_W-1:0] S_AXI_WDATA,
    input  logic [STRB_W-1:0] S_AXI_WSTRB,
    input  logic              S_AXI_WLAST,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [ID_W-1:0]   S_AXI_BID,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ID_W-1:0]   S_AXI_ARID,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic [2:0]        S_AXI_ARSIZE,
    input  logic [1:0]        S_AXI_ARBURST,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [ID_W-1:0]   S_AXI_RID,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

`ifdef AXI_SLV_BACKPRESSURE_EN
    localparam logic BUBBLE_EN = 1'b1;
`else
    localparam logic BUBBLE_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [MEM_AW-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d, w_lat_q, w_lat_d;
    logic              w_incr_q, w_incr_d, w_err_q, w_err_d;
    logic              w_last_err_q, w_last_err_d, w_bub_q, w_bub_d;
    logic              mem_we;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [MEM_AW-1:0] r_addr_q, r_addr_d, r_next_addr;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_lat_q, r_lat_d;
    logic              r_incr_q, r_incr_d, r_err_q, r_err_d, r_bub_q, r_bub_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    // Write path state register
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q    <= W_IDLE;
            w_id_q       <= '0;
            w_addr_q     <= '0;
            w_len_q      <= '0;
            w_cnt_q      <= '0;
            w_lat_q      <= '0;
            w_incr_q     <= 1'b0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
            w_bub_q      <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            w_id_q       <= w_id_d;
            w_addr_q     <= w_addr_d;
            w_len_q      <= w_len_d;
            w_cnt_q      <= w_cnt_d;
            w_lat_q      <= w_lat_d;
            w_incr_q     <= w_incr_d;
            w_err_q      <= w_err_d;
            w_last_err_q <= w_last_err_d;
            w_bub_q      <= w_bub_d;
        end
    end

    // Write path next state and channel outputs
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_d     = w_state_q;
        w_id_d        = w_id_q;
        w_addr_d      = w_addr_q;
        w_len_d       = w_len_q;
        w_cnt_d       = w_cnt_q;
        w_lat_d       = w_lat_q;
        w_incr_d      = w_incr_q;
        w_err_d       = w_err_q;
        w_last_err_d  = w_last_err_q;
        w_bub_d       = 1'b0;
        mem_we        = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        case (w_state_q)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) begin
                    w_id_d       = S_AXI_AWID;
                    w_addr_d     = S_AXI_AWADDR[ADDR_W-1:OFF_W];
                    w_len_d      = S_AXI_AWLEN;
                    w_incr_d     = (S_AXI_AWBURST == BURST_INCR);
                    // WRAP (and the reserved encoding) or a narrow/wide SIZE is refused.
                    w_err_d      = S_AXI_AWBURST[1] || (S_AXI_AWSIZE != 3'(OFF_W));
                    w_last_err_d = 1'b0;
                    w_cnt_d      = '0;
                    w_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = !w_bub_q;
                if (S_AXI_WVALID && !w_bub_q) begin
                    mem_we  = !w_err_q;
                    w_bub_d = BUBBLE_EN;
                    // Burst end is decided by the beat count; WLAST is only cross-checked.
                    if (S_AXI_WLAST != (w_cnt_q == w_len_q))
                        w_last_err_d = 1'b1;
                    if (w_cnt_q == w_len_q) begin
                        w_lat_d   = '0;
                        w_state_d = W_DELAY;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (w_incr_q)
                            w_addr_d = w_addr_q + MEM_AW'(1);
                    end
                end
            end
            W_DELAY: begin
                if (w_lat_q == 8'(WR_LAT - 1))
                    w_state_d = W_RESP;
                else
                    w_lat_d = w_lat_q + 8'd1;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = (w_err_q || w_last_err_q) ? RESP_SLVERR : RESP_OKAY;
                if (S_AXI_BREADY)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign S_AXI_BID = w_id_q;

    // Memory write port with per-byte strobes
    // NOTE: the array has no reset; its contents must survive ARESETN and it maps onto RAM.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[w_addr_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Read path state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
            r_incr_q  <= 1'b0;
            r_err_q   <= 1'b0;
            r_bub_q   <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_lat_q   <= r_lat_d;
            r_incr_q  <= r_incr_d;
            r_err_q   <= r_err_d;
            r_bub_q   <= r_bub_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_next_addr = r_incr_q ? r_addr_q + MEM_AW'(1) : r_addr_q;

    // Read path next state; the data register is loaded from memory at the edge
    // a beat becomes current, so a same-edge write is seen only by later beats.
    always_comb begin
        r_state_d     = r_state_q;
        r_id_d        = r_id_q;
        r_addr_d      = r_addr_q;
        r_len_d       = r_len_q;
        r_cnt_d       = r_cnt_q;
        r_lat_d       = r_lat_q;
        r_incr_d      = r_incr_q;
        r_err_d       = r_err_q;
        r_bub_d       = 1'b0;
        r_data_d      = r_data_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) begin
                    r_id_d    = S_AXI_ARID;
                    r_addr_d  = S_AXI_ARADDR[ADDR_W-1:OFF_W];
                    r_len_d   = S_AXI_ARLEN;
                    r_incr_d  = (S_AXI_ARBURST == BURST_INCR);
                    r_err_d   = S_AXI_ARBURST[1] || (S_AXI_ARSIZE != 3'(OFF_W));
                    r_lat_d   = '0;
                    r_state_d = R_DELAY;
                end
            end
            R_DELAY: begin
                if (r_lat_q == 8'(RD_LAT - 1)) begin
                    r_cnt_d   = '0;
                    r_data_d  = r_err_q ? '0 : mem[r_addr_q];
                    r_state_d = R_DATA;
                end else begin
                    r_lat_d = r_lat_q + 8'd1;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = !r_bub_q;
                if (S_AXI_RREADY && !r_bub_q) begin
                    r_bub_d = BUBBLE_EN;
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_addr_d = r_next_addr;
                        r_data_d = r_err_q ? '0 : mem[r_next_addr];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign S_AXI_RID   = r_id_q;
    assign S_AXI_RDATA = r_data_q;
    assign S_AXI_RLAST = S_AXI_RVALID && (r_cnt_q == r_len_q);
    assign S_AXI_RRESP = (S_AXI_RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_full_slave_latency_mem.sv
// tb_axi_full_slave_latency_mem -- randomized self-checking bench for
// axi_full_slave_latency_mem; a flat array models the memory contents and
// expected responses are derived from the burst rules.
module tb_axi_full_slave_latency_mem;

    localparam int ID_W   = 1;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 8;
    localparam int WR_LAT = 4;
    localparam int RD_LAT = 4;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int ADDR_W = MEM_AW + 2;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ID_W-1:0]   awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wdata_arr [256];
    logic [3:0]        wstrb_arr [256];

    always #5 clk = ~clk;

    axi_full_slave_latency_mem #(
        .ID_W(ID_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
    ) dut (
        .S_AXI_ACLK(clk),        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid),       .S_AXI_AWADDR(awaddr),   .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize),   .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),     .S_AXI_WSTRB(wstrb),     .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BID(bid),         .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid),       .S_AXI_ARADDR(araddr),   .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize),   .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid),         .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast),     .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready)
    );

    // Global time limit so no wait on the DUT can hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "time limit reached");
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input int base, input int beat, input logic [1:0] burst);
        return (burst == INCR) ? (base + beat) % DEPTH : base;
    endfunction

    // Full write burst; the model is updated from the burst rules, then response
    // latency, BRESP and BID are checked.
    task automatic do_write(input logic [ID_W-1:0] id, input int word, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int last_at, input string tag);
        bit          err;
        int          cyc, a;
        logic [1:0]  exp_resp;
        err      = burst[1] || (size != 3'd2);
        exp_resp = (err || last_at != len) ? 2'b10 : 2'b00;
        awid     = id;
        awaddr   = {MEM_AW'(word), 2'($urandom_range(0, 3))};
        awlen    = 8'(len);
        awsize   = size;
        awburst  = burst;
        awvalid  = 1'b1;
        while (!awready) step();
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata  = wdata_arr[i];
            wstrb  = wstrb_arr[i];
            wlast  = (i == last_at);
            wvalid = 1'b1;
            while (!wready) step();
            step();
            if (!err) begin
                a = word_of(word, i, burst);
                for (int b = 0; b < 4; b++)
                    if (wstrb_arr[i][b]) ref_mem[a][8*b +: 8] = wdata_arr[i][8*b +: 8];
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        cyc    = 0;
        while (!bvalid) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != WR_LAT) begin
            errors++;
            $display("FAIL %s b_latency: got %0d cycles, required %0d", tag, cyc, WR_LAT);
        end
        repeat ($urandom_range(0, 2)) begin
            step();
            checks++;
            if (bvalid !== 1'b1) begin
                errors++;
                $display("FAIL %s bvalid_hold: got %b, required 1", tag, bvalid);
            end
        end
        checks++;
        if (bresp !== exp_resp) begin
            errors++;
            $display("FAIL %s bresp: got %b, required %b", tag, bresp, exp_resp);
        end
        checks++;
        if (bid !== id) begin
            errors++;
            $display("FAIL %s bid: got %h, required %h", tag, bid, id);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s bvalid_drop: got %b, required 0", tag, bvalid);
        end
    endtask

    // Full read burst. rmode: 0 RREADY high, 1 RREADY toggling, 2 random RREADY.
    // Every cycle RVALID is high (stalled or not) data/last/resp/id are checked
    // against the current beat's expected values.
    task automatic do_read(input logic [ID_W-1:0] id, input int word, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int rmode, input string tag);
        bit                err, tgl;
        int                cyc, beat;
        logic [DATA_W-1:0] exp_data;
        logic [1:0]        exp_resp;
        err      = burst[1] || (size != 3'd2);
        exp_resp = err ? 2'b10 : 2'b00;
        arid     = id;
        araddr   = {MEM_AW'(word), 2'($urandom_range(0, 3))};
        arlen    = 8'(len);
        arsize   = size;
        arburst  = burst;
        arvalid  = 1'b1;
        while (!arready) step();
        step();
        arvalid = 1'b0;
        cyc     = 0;
        while (!rvalid) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != RD_LAT) begin
            errors++;
            $display("FAIL %s r_latency: got %0d cycles, required %0d", tag, cyc, RD_LAT);
        end
        beat = 0;
        tgl  = 1'b0;
        while (beat <= len) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       begin rready = tgl; tgl = ~tgl; end
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid) begin
                exp_data = err ? '0 : ref_mem[word_of(word, beat, burst)];
                checks++;
                if (rdata !== exp_data) begin
                    errors++;
                    $display("FAIL %s rdata beat %0d: got %h, required %h", tag, beat, rdata, exp_data);
                end
                checks++;
                if (rlast !== (beat == len)) begin
                    errors++;
                    $display("FAIL %s rlast beat %0d: got %b, required %b", tag, beat, rlast, beat == len);
                end
                checks++;
                if (rresp !== exp_resp || rid !== id) begin
                    errors++;
                    $display("FAIL %s rresp/rid beat %0d: got %b/%h, required %b/%h",
                             tag, beat, rresp, rid, exp_resp, id);
                end
                if (rready) beat++;
            end
            step();
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s rvalid_after_last: got %b, required 0", tag, rvalid);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000
            || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got aw/ar/w/b/rv/rl=%b%b%b%b%b%b bresp=%b rresp=%b, required 110000 00 00",
                     awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            wdata_arr[i] = $urandom;
            wstrb_arr[i] = 4'hF;
        end
        do_write(1'b0, 0, 255, 3'd2, INCR, 255, "fill");
        do_read(1'b1, 0, 255, 3'd2, INCR, 0, "fill_rd");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            wdata_arr[i] = 32'hA0 + i;
            wstrb_arr[i] = 4'hF;
        end
        do_write(1'b1, 32'h10 >> 2, 3, 3'd2, INCR, 3, "basic_wr");
        do_read(1'b0, 32'h10 >> 2, 3, 3'd2, INCR, 0, "basic_rd");
        do_read(1'b1, 9, 0, 3'd2, INCR, 0, "single_beat");
    endtask

    task automatic test_rready_toggle();
        do_read(1'b1, 2, 7, 3'd2, INCR, 1, "rready_toggle");
    endtask

    task automatic test_addr_wrap();
        for (int i = 0; i < 4; i++) begin
            wdata_arr[i] = $urandom;
            wstrb_arr[i] = 4'hF;
        end
        do_write(1'b0, DEPTH - 1, 3, 3'd2, INCR, 3, "wrap_addr_wr");
        do_read(1'b0, DEPTH - 4, 7, 3'd2, INCR, 2, "wrap_addr_rd");
    endtask

    task automatic test_fixed_strobe();
        for (int i = 0; i < 4; i++) begin
            wdata_arr[i] = $urandom;
            wstrb_arr[i] = 4'(1 << i);
        end
        do_write(1'b1, 80, 3, 3'd2, FIXED, 3, "fixed_wr");
        do_read(1'b1, 80, 2, 3'd2, FIXED, 2, "fixed_rd");
        do_read(1'b0, 79, 2, 3'd2, INCR, 0, "fixed_nbr");
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin
            wdata_arr[i] = $urandom;
            wstrb_arr[i] = 4'hF;
        end
        do_write(1'b1, 60, 3, 3'd2, WRAP, 3, "wrap_burst_wr");
        do_read(1'b0, 60, 3, 3'd2, INCR, 0, "wrap_unchanged");
        do_read(1'b1, 60, 3, 3'd2, WRAP, 0, "wrap_burst_rd");
        do_write(1'b0, 64, 0, 3'd1, INCR, 0, "bad_size_wr");
        do_read(1'b0, 64, 0, 3'd1, INCR, 0, "bad_size_rd");
        do_read(1'b0, 64, 0, 3'd2, INCR, 0, "bad_size_unchanged");
        do_write(1'b1, 70, 3, 3'd2, INCR, 1, "wlast_early");
        do_read(1'b1, 70, 3, 3'd2, INCR, 0, "wlast_early_data");
        do_write(1'b0, 90, 1, 3'd2, INCR, -1, "wlast_missing");
        do_read(1'b0, 90, 1, 3'd2, INCR, 0, "wlast_missing_data");
    endtask

    // Read data for word 40 is captured on the same edge the write beat lands.
    task automatic test_same_cycle();
        logic [DATA_W-1:0] old_val, new_val;
        old_val = ref_mem[40];
        new_val = ~old_val;
        arid = 1'b0; araddr = {MEM_AW'(40), 2'b00}; arlen = 8'd0; arsize = 3'd2;
        arburst = INCR; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        repeat (RD_LAT - 2) step();
        awid = 1'b1; awaddr = {MEM_AW'(40), 2'b00}; awlen = 8'd0; awsize = 3'd2;
        awburst = INCR; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wdata = new_val; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
        ref_mem[40] = new_val;
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_val) begin
            errors++;
            $display("FAIL same_cycle: got rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, old_val);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        bready = 1'b1;
        while (!bvalid) step();
        checks++;
        if (bresp !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_bresp: got %b, required 00", bresp);
        end
        step();
        bready = 1'b0;
        do_read(1'b1, 40, 0, 3'd2, INCR, 0, "same_cycle_after");
    endtask

    task automatic test_random();
        int word, len;
        logic [1:0] burst;
        for (int n = 0; n < 30; n++) begin
            word  = $urandom_range(0, DEPTH - 1);
            len   = $urandom_range(0, 15);
            burst = $urandom_range(0, 1) ? INCR : FIXED;
            for (int i = 0; i <= len; i++) begin
                wdata_arr[i] = $urandom;
                wstrb_arr[i] = 4'($urandom);
            end
            do_write(1'($urandom), word, len, 3'd2, burst, len, "rand_wr");
            do_read(1'($urandom), word, len, 3'd2, INCR, $urandom_range(0, 2), "rand_rd");
        end
    endtask

    task automatic test_reset_mid_read();
        arid = 1'b0; araddr = {MEM_AW'(4), 2'b00}; arlen = 8'd3; arsize = 3'd2;
        arburst = INCR; arvalid = 1'b1;
        while (!arready) step();
        step();
        arvalid = 1'b0;
        while (!rvalid) step();
        rready = 1'b1;
        step();
        rready = 1'b0;
        while (!rvalid) step();
        checks++;
        if (rdata !== ref_mem[5]) begin
            errors++;
            $display("FAIL rst_beat2_data: got %h, required %h", rdata, ref_mem[5]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got rvalid=%b rlast=%b bvalid=%b, required 0 0 0", rvalid, rlast, bvalid);
        end
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got ar=%b aw=%b, required 1 1", arready, awready);
        end
        do_read(1'b1, 4, 3, 3'd2, INCR, 0, "rst_readback");
        do_read(1'b0, DEPTH - 2, 3, 3'd2, INCR, 2, "rst_readback_wrap");
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_rready_toggle();
        test_addr_wrap();
        test_fixed_strobe();
        test_errors();
        test_same_cycle();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
